// File: rtl/clock_display_scan.sv
// Six-digit multiplexed seven-segment scanner for HH:MM:SS with a per-frame time snapshot and hours blink.
// Optional build macro CLOCK_12H_EN selects 12-hour display with a PM indicator on the slot-0 decimal point.
module clock_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [5:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    input  logic       adjust,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_done
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        case (d)
            4'd0:    seven_seg = 7'b1000000;
            4'd1:    seven_seg = 7'b1111001;
            4'd2:    seven_seg = 7'b0100100;
            4'd3:    seven_seg = 7'b0110000;
            4'd4:    seven_seg = 7'b0011001;
            4'd5:    seven_seg = 7'b0010010;
            4'd6:    seven_seg = 7'b0000010;
            4'd7:    seven_seg = 7'b1111000;
            4'd8:    seven_seg = 7'b0000000;
            4'd9:    seven_seg = 7'b0010000;
            default: seven_seg = SEG_OFF;
        endcase
    endfunction

    logic [PW-1:0] pcnt, pcnt_n;
    logic [2:0]    idx, idx_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          phase_hidden, phase_hidden_n;
    logic [5:0]    snap_h, snap_m, snap_s;
    logic [5:0]    snap_h_n, snap_m_n, snap_s_n;

    logic          pcnt_wrap, frame_end, take_snap;
    logic          hours_bad, pm;
    logic [5:0]    hours_shown, field;
    logic          field_bad;
    logic [3:0]    tens, units, digit;
    logic          blank, hide;
    logic [6:0]    seg_n;
    logic [5:0]    an_n;
    logic          dp_n, frame_done_n;

    // Everything is computed for the state after the coming edge, so the
    // registered outputs line up with the pcnt/idx they describe.
    always_comb begin
        pcnt_wrap = (pcnt == PW'(SCAN_DIV - 1));
        frame_end = pcnt_wrap && (idx == 3'd5);
        pcnt_n    = pcnt_wrap ? '0 : pcnt + PW'(1);
        idx_n     = idx;
        if (pcnt_wrap) idx_n = (idx == 3'd5) ? 3'd0 : idx + 3'd1;

        take_snap = (pcnt == '0) && (idx == 3'd0);
        snap_h_n  = take_snap ? hours   : snap_h;
        snap_m_n  = take_snap ? minutes : snap_m;
        snap_s_n  = take_snap ? seconds : snap_s;

        fcnt_n         = fcnt;
        phase_hidden_n = phase_hidden;
        if (!adjust) begin
            fcnt_n         = '0;
            phase_hidden_n = 1'b0;
        end else if (frame_end) begin
            if (fcnt == FW'(BLINK_DIV - 1)) begin
                fcnt_n         = '0;
                phase_hidden_n = ~phase_hidden;
            end else begin
                fcnt_n = fcnt + FW'(1);
            end
        end
    end

    always_comb begin
        hours_bad = (snap_h_n > 6'd23);
`ifdef CLOCK_12H_EN
        if (snap_h_n == 6'd0)      hours_shown = 6'd12;
        else if (snap_h_n > 6'd12) hours_shown = snap_h_n - 6'd12;
        else                       hours_shown = snap_h_n;
        pm = !hours_bad && (snap_h_n >= 6'd12);
`else
        hours_shown = snap_h_n;
        pm          = 1'b0;
`endif
        case (idx_n)
            3'd0, 3'd1: begin field = snap_s_n; field_bad = (snap_s_n > 6'd59); end
            3'd2, 3'd3: begin field = snap_m_n; field_bad = (snap_m_n > 6'd59); end
            default:    begin field = hours_shown; field_bad = hours_bad; end
        endcase
        tens  = 4'(field / 6'd10);
        units = 4'(field % 6'd10);
        digit = idx_n[0] ? tens : units;
        seg_n = field_bad ? SEG_DASH : seven_seg(digit);

        // Hours tens is blanked only for a real leading zero, never for a dash.
        blank = (idx_n == 3'd5) && !hours_bad && (tens == 4'd0);
        hide  = adjust && phase_hidden_n && (idx_n >= 3'd4);
        an_n  = ((pcnt_n == '0) || blank || hide) ? 6'b111111 : ~(6'b000001 << idx_n);
        dp_n  = ~((idx_n == 3'd2) || (idx_n == 3'd4) || ((idx_n == 3'd0) && pm));
        frame_done_n = (idx_n == 3'd5) && (pcnt_n == PW'(SCAN_DIV - 1));
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            pcnt         <= '0;
            idx          <= 3'd0;
            fcnt         <= '0;
            phase_hidden <= 1'b0;
            snap_h       <= 6'd0;
            snap_m       <= 6'd0;
            snap_s       <= 6'd0;
            an           <= 6'b111111;
            seg          <= SEG_OFF;
            dp           <= 1'b1;
            frame_done   <= 1'b0;
        end else begin
            pcnt         <= pcnt_n;
            idx          <= idx_n;
            fcnt         <= fcnt_n;
            phase_hidden <= phase_hidden_n;
            snap_h       <= snap_h_n;
            snap_m       <= snap_m_n;
            snap_s       <= snap_s_n;
            an           <= an_n;
            seg          <= seg_n;
            dp           <= dp_n;
            frame_done   <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Bench for clock_display_scan: directed and random time values checked every cycle against a frame-level model.
module tb_clock_display_scan;

    localparam int SD    = 4;
    localparam int BD    = 2;
    localparam int FRAME = 6 * SD;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       adjust = 1'b0;
    logic [5:0] hours = 6'd0;
    logic [5:0] minutes = 6'd0;
    logic [5:0] seconds = 6'd0;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_done;

    always #5 clk = ~clk;

    clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .clear      (clear),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .adjust     (adjust),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    int total = 0;
    int bad   = 0;

    // Model: t is the cycle index since the frame started after clear.
    int t = 0;
    bit started = 0;
    bit in_rst = 0;
    bit hid = 0;
    int adj_frames = 0;
    int snap_h = 0, snap_m = 0, snap_s = 0;

    function automatic logic [6:0] font(input int d);
        case (d)
            0: font = 7'b1000000;
            1: font = 7'b1111001;
            2: font = 7'b0100100;
            3: font = 7'b0110000;
            4: font = 7'b0011001;
            5: font = 7'b0010010;
            6: font = 7'b0000010;
            7: font = 7'b1111000;
            8: font = 7'b0000000;
            9: font = 7'b0010000;
            default: font = 7'b1111111;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
        end
    endtask

    task automatic model_step();
        if (clear) begin
            t = 0; in_rst = 1; started = 1; hid = 0;
            adj_frames = 0; snap_h = 0; snap_m = 0; snap_s = 0;
        end else if (started) begin
            if (t % FRAME == 0) begin
                snap_h = hours; snap_m = minutes; snap_s = seconds;
            end
            if (!adjust) adj_frames = 0;
            else if (t % FRAME == FRAME - 1) adj_frames++;
            t++;
            in_rst = 0;
            hid = adjust && (((adj_frames / BD) % 2) == 1);
        end
    endtask

    task automatic check_outputs();
        int pos, slot, hd, val;
        bit hbad, pm, dash, lit;
        int dig[6];
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        if (!started) return;
        if (in_rst) begin
            cmp("rst_an", {1'b0, an}, 7'h3F);
            cmp("rst_seg", seg, 7'h7F);
            cmp("rst_dp", {6'd0, dp}, 7'd1);
            cmp("rst_fd", {6'd0, frame_done}, 7'd0);
            return;
        end
        pos  = t % SD;
        slot = (t / SD) % 6;
        hbad = snap_h > 23;
`ifdef CLOCK_12H_EN
        hd = (snap_h == 0) ? 12 : ((snap_h > 12) ? snap_h - 12 : snap_h);
        pm = !hbad && snap_h >= 12;
`else
        hd = snap_h;
        pm = 0;
`endif
        dig[0] = snap_s % 10; dig[1] = snap_s / 10;
        dig[2] = snap_m % 10; dig[3] = snap_m / 10;
        dig[4] = hd % 10;     dig[5] = hd / 10;
        dash = (slot < 2) ? (snap_s > 59) : ((slot < 4) ? (snap_m > 59) : hbad);
        val  = dig[slot];
        lit  = (pos != 0) && !(slot == 5 && !hbad && dig[5] == 0) && !(slot >= 4 && hid);
        e_an  = lit ? ~(6'b000001 << slot) : 6'b111111;
        e_seg = dash ? 7'b0111111 : font(val);
        e_dp  = !(slot == 2 || slot == 4 || (slot == 0 && pm));
        cmp("fd", {6'd0, frame_done}, {6'd0, (slot == 5 && pos == SD - 1)});
        cmp("an", {1'b0, an}, {1'b0, e_an});
        if (pos != 0) begin
            cmp("seg", seg, e_seg);
            cmp("dp", {6'd0, dp}, {6'd0, e_dp});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    int hv_list[6] = '{30, 7, 0, 13, 12, 9};

    initial begin
        // Reset, then 23:59:58 for two full frames.
        hours = 6'd23; minutes = 6'd59; seconds = 6'd58;
        run(3);
        clear = 1'b0;
        run(2 * FRAME);

        // Clear in the middle of a frame.
        run(7);
        clear = 1'b1;
        run(1);
        clear = 1'b0;
        run(FRAME);

        // Minutes change during slot 3 must wait for the next frame.
        for (int k = 0; k < FRAME && ((t % FRAME) / SD) != 3; k++) tick();
        minutes = 6'd0;
        run(2 * FRAME);

        // Range, leading-zero and 12-hour boundary values.
        foreach (hv_list[i]) begin
            hours = 6'(hv_list[i]);
            run(2 * FRAME);
        end
        minutes = 6'd60;
        seconds = 6'd63;
        run(2 * FRAME);
        minutes = 6'd34;
        seconds = 6'd5;

        // Blink, then drop adjust while the hours are dark.
        hours = 6'd18;
        adjust = 1'b1;
        run(6 * FRAME);
        for (int k = 0; k < 8 * FRAME && !(hid && ((t % FRAME) / SD) == 1); k++) tick();
        adjust = 1'b0;
        run(2 * FRAME);

        // clear wins over adjust.
        adjust = 1'b1;
        clear = 1'b1;
        run(2);
        clear = 1'b0;
        run(3 * FRAME);
        adjust = 1'b0;

        // Random time values, adjust and occasional clears.
        repeat (150) begin
            hours   = 6'($urandom_range(0, 31));
            minutes = 6'($urandom_range(0, 63));
            seconds = 6'($urandom_range(0, 63));
            adjust  = ($urandom_range(0, 3) == 0);
            clear   = ($urandom_range(0, 24) == 0);
            run(1);
            clear = 1'b0;
            run($urandom_range(1, 40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
